opb_register_simulink2ppc: RTL and testbench

- OPB slave that returns fabric (Simulink) data to the PowerPC; the opposite direction of the ppc2simulink software register.
- User logic presents a 32-bit word with a one-cycle strobe; the block captures it, tracks new-data/overrun status and serves reads on OPB.
- Single clock domain: user logic runs on OPB_Clk.
- Instantiated per software-readable register inside the XPS OPB bus wrapper.

---
 rtl/opb_register_simulink2ppc.sv | 199 +++++++++++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_simulink2ppc.sv
// ============================================================================
// opb_register_simulink2ppc
// OPB slave that returns a strobed fabric word to the PowerPC, with
// new-data / overrun status and a freeze control bit.
// Optional TSTAMP capture counter: define OPB_S2P_TIMESTAMP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module opb_register_simulink2ppc #(
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid,
    output logic                    user_frozen
);

    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_ctrl   = 2'd2;
    localparam logic [1:0] c_reg_tstamp = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_ack;
    logic [31:0] r_dout;
    logic        r_rnw;
    logic [1:0]  r_reg;
    logic        r_wfrz;
    logic        r_be3;

    logic [31:0] r_data;
    logic        r_new;
    logic [15:0] r_ovr;
    logic        r_freeze;

    logic [31:0] w_off;
    logic        w_hit;
    logic [1:0]  w_reg;
    logic [31:0] w_tstamp;
    logic [31:0] w_rmux;
    logic        w_in_ack;
    logic        w_rd_data;
    logic        w_wr_status;
    logic        w_wr_ctrl;
    logic        w_capture;
    logic        w_count;

    // Offset compare keeps the window test correct for any base without a
    // constant-true lower-bound comparison when the base is zero.
    assign w_off = OPB_ABus - C_BASEADDR;
    assign w_hit = OPB_select && (w_off <= (C_HIGHADDR - C_BASEADDR));
    assign w_reg = OPB_ABus[28:29];

`ifdef OPB_S2P_TIMESTAMP_EN
    logic [31:0] r_cycles;
    logic [31:0] r_tstamp;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_cycles <= 32'd0;
            r_tstamp <= 32'd0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_capture) begin
                r_tstamp <= r_cycles;
            end
        end
    end

    assign w_tstamp = r_tstamp;
`else
    assign w_tstamp = 32'd0;
`endif

    always_comb begin
        w_rmux = 32'd0;
        case (w_reg)
            c_reg_data:   w_rmux = r_data;
            c_reg_status: w_rmux = {r_ovr, 15'd0, r_new};
            c_reg_ctrl:   w_rmux = {31'd0, r_freeze};
            c_reg_tstamp: w_rmux = w_tstamp;
            default:      w_rmux = 32'd0;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_dout  <= 32'd0;
            r_rnw   <= 1'b0;
            r_reg   <= 2'd0;
            r_wfrz  <= 1'b0;
            r_be3   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_dout  <= OPB_RNW ? w_rmux : 32'd0;
                        r_rnw   <= OPB_RNW;
                        r_reg   <= w_reg;
                        r_wfrz  <= OPB_DBus[C_OPB_DWIDTH-1];
                        r_be3   <= OPB_BE[3];
                    end
                end
                S_ACK: begin
                    r_state <= S_HOLD;
                    r_ack   <= 1'b0;
                    r_dout  <= 32'd0;
                end
                S_HOLD: begin
                    if (!OPB_select) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_dout  <= 32'd0;
                end
            endcase
        end
    end

    // Bus side effects commit on the ACK cycle using the IDLE-sampled request.
    assign w_in_ack    = (r_state == S_ACK);
    assign w_rd_data   = w_in_ack &&  r_rnw && (r_reg == c_reg_data);
    assign w_wr_status = w_in_ack && !r_rnw && (r_reg == c_reg_status);
    assign w_wr_ctrl   = w_in_ack && !r_rnw && (r_reg == c_reg_ctrl) && r_be3;

    assign w_capture = user_data_valid && !r_freeze;
    assign w_count   = user_data_valid && (r_freeze || r_new);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_data   <= 32'd0;
            r_new    <= 1'b0;
            r_ovr    <= 16'd0;
            r_freeze <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data <= user_data_in;
            end
            // A strobe landing on the DATA-read ack keeps the flag set.
            if (w_capture) begin
                r_new <= 1'b1;
            end else if (w_rd_data) begin
                r_new <= 1'b0;
            end
            if (w_wr_status) begin
                r_ovr <= {15'd0, w_count};
            end else if (w_count && (r_ovr != 16'hFFFF)) begin
                r_ovr <= r_ovr + 16'd1;
            end
            if (w_wr_ctrl) begin
                r_freeze <= r_wfrz;
            end
        end
    end

    assign Sl_DBus     = r_dout;
    assign Sl_xferAck  = r_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_frozen = r_freeze;

    logic w_unused;
    assign w_unused = &{1'b0, OPB_seqAddr, OPB_BE[0:2],
                        OPB_DBus[0:C_OPB_DWIDTH-2], (C_FAMILY == "")};

endmodule

`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc.sv
// ============================================================================
// tb_opb_register_simulink2ppc
// Directed self-checking bench for the simulink-to-PPC OPB register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_opb_register_simulink2ppc;

    logic        clk;
    logic        rst_n;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_data_valid;
    logic        user_frozen;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] r_cyc;
    logic [31:0] r_stamp_exp;

    localparam logic [31:0] c_a_data   = 32'h0000_0000;
    localparam logic [31:0] c_a_status = 32'h0000_0004;
    localparam logic [31:0] c_a_ctrl   = 32'h0000_0008;
    localparam logic [31:0] c_a_tstamp = 32'h0000_000C;

    opb_register_simulink2ppc dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .OPB_ABus        (OPB_ABus),
        .OPB_BE          (OPB_BE),
        .OPB_DBus        (OPB_DBus),
        .OPB_RNW         (OPB_RNW),
        .OPB_select      (OPB_select),
        .OPB_seqAddr     (OPB_seqAddr),
        .Sl_DBus         (Sl_DBus),
        .Sl_xferAck      (Sl_xferAck),
        .Sl_errAck       (Sl_errAck),
        .Sl_retry        (Sl_retry),
        .Sl_toutSup      (Sl_toutSup),
        .user_data_in    (user_data_in),
        .user_data_valid (user_data_valid),
        .user_frozen     (user_frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release, used as the expected capture timestamp.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cyc <= 32'd0;
        else        r_cyc <= r_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic opb_xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic strobe_on_ack,
                            input logic [31:0] sdata, output logic [31:0] rdata,
                            output int lat);
        lat   = 0;
        rdata = 32'd0;
        @(negedge clk);
        OPB_ABus   = addr;
        OPB_BE     = be;
        OPB_DBus   = wdata;
        OPB_RNW    = rnw;
        OPB_select = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (Sl_xferAck) begin
                lat   = i;
                rdata = Sl_DBus;
                break;
            end
        end
        if (strobe_on_ack && lat != 0) begin
            user_data_in    = sdata;
            user_data_valid = 1'b1;
        end
        OPB_select = 1'b0;
        OPB_RNW    = 1'b0;
        OPB_DBus   = 32'd0;
        @(posedge clk); #1;
        user_data_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int          lat;
        opb_xfer(1'b1, addr, 4'b1111, 32'd0, 1'b0, 32'd0, d, lat);
        chk({tag, "_lat"}, lat, 1);
        chk(tag, d, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] data);
        logic [31:0] d;
        int          lat;
        opb_xfer(1'b0, addr, be, data, 1'b0, 32'd0, d, lat);
        chk({tag, "_lat"}, lat, 1);
    endtask

    task automatic strobe(input logic [31:0] d);
        @(negedge clk);
        user_data_in    = d;
        user_data_valid = 1'b1;
        r_stamp_exp     = r_cyc;
        @(negedge clk);
        user_data_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          n_ack;

        rst_n           = 1'b0;
        OPB_ABus        = 32'd0;
        OPB_BE          = 4'b0000;
        OPB_DBus        = 32'd0;
        OPB_RNW         = 1'b0;
        OPB_select      = 1'b0;
        OPB_seqAddr     = 1'b0;
        user_data_in    = 32'd0;
        user_data_valid = 1'b0;
        r_stamp_exp     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, Sl_xferAck}, 32'd0);
        chk("rst_dbus", Sl_DBus, 32'd0);
        chk("rst_frozen", {31'd0, user_frozen}, 32'd0);
        rst_n = 1'b1;

        rd("rst_data", c_a_data, 32'd0);
        rd("rst_status", c_a_status, 32'd0);
        chk("tied_zero", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);

        strobe(32'hDEADBEEF);
        rd("data_beef", c_a_data, 32'hDEADBEEF);
        rd("status_after_read", c_a_status, 32'h0000_0000);

        strobe(32'h0000_0001);
        strobe(32'h0000_0002);
        strobe(32'h0000_0003);
        rd("status_ovr2", c_a_status, 32'h0002_0001);
        wr("wr_status", c_a_status, 4'b1111, 32'hFFFF_FFFF);
        rd("status_cleared", c_a_status, 32'h0000_0001);

        wr("wr_freeze", c_a_ctrl, 4'b0001, 32'h0000_0001);
        chk("frozen_set", {31'd0, user_frozen}, 32'd1);
        rd("ctrl_read", c_a_ctrl, 32'h0000_0001);
        strobe(32'h1234_5678);
        rd("data_frozen", c_a_data, 32'h0000_0003);
        rd("status_frozen", c_a_status, 32'h0001_0000);
        wr("wr_ctrl_nobe", c_a_ctrl, 4'b0000, 32'h0000_0000);
        chk("frozen_kept", {31'd0, user_frozen}, 32'd1);
        wr("wr_unfreeze", c_a_ctrl, 4'b0001, 32'h0000_0000);
        chk("frozen_clr", {31'd0, user_frozen}, 32'd0);

        strobe(32'h1111_1111);
        opb_xfer(1'b1, c_a_data, 4'b1111, 32'd0, 1'b1, 32'hA5A5A5A5, d, lat);
        chk("coinc_lat", lat, 1);
        chk("coinc_old", d, 32'h1111_1111);
        opb_xfer(1'b1, c_a_status, 4'b1111, 32'd0, 1'b0, 32'd0, d, lat);
        chk("coinc_new", d & 32'h0000_0001, 32'h0000_0001);
        rd("coinc_data", c_a_data, 32'hA5A5A5A5);

        wr("wr_data_ign", c_a_data, 4'b1111, 32'h0BAD_0BAD);
        rd("data_unchanged", c_a_data, 32'hA5A5A5A5);

`ifdef OPB_S2P_TIMESTAMP_EN
        strobe(32'h0000_0077);
        rd("tstamp", c_a_tstamp, r_stamp_exp);
`else
        rd("tstamp_off", c_a_tstamp, 32'd0);
`endif

        @(negedge clk);
        OPB_ABus   = 32'h0000_0100;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        n_ack      = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (Sl_xferAck) n_ack++;
        end
        chk("miss_noack", n_ack, 0);
        chk("miss_dbus", Sl_DBus, 32'd0);
        OPB_select = 1'b0;
        repeat (2) @(posedge clk);

        @(negedge clk);
        OPB_ABus   = c_a_data;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        n_ack      = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (Sl_xferAck) n_ack++;
        end
        OPB_select = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (Sl_xferAck) n_ack++;
        end
        chk("hold_one_ack", n_ack, 1);

        wr("wr_freeze2", c_a_ctrl, 4'b0001, 32'h0000_0001);
        @(negedge clk);
        OPB_ABus   = c_a_data;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack_before", {31'd0, Sl_xferAck}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack_drop", {31'd0, Sl_xferAck}, 32'd0);
        chk("midrst_frozen", {31'd0, user_frozen}, 32'd0);
        OPB_select = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd("midrst_data", c_a_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
